rle_decoder: RTL and testbench

Run-length decoder for the RLE datapath: accepts (symbol, run-length) pairs over a valid/ready input channel and expands each pair into a stream of repeated 32-bit words on a valid/ready output channel. It is the receive-side counterpart of the RLE encoder. It sits between the compressed-stream buffer and the downstream word consumer. It sustains one output word per cycle, with no bubble between consecutive runs.

---
 rtl/rle_decoder.sv | 78 +++++++
 tb/tb_rle_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (symbol, run-length) pairs into a stream of
// repeated words over valid/ready channels, one word per cycle.
module rle_decoder #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int PAIR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [PAIR_W-1:0] pairs_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  rem_q;
  logic [PAIR_W-1:0] pairs_q;
  logic              run;
  logic              rem_zero;

  assign run      = (state == RUN);
  assign rem_zero = (rem_q == '0);

  // in_ready is combinational from out_ready so the next pair can load on
  // the last-word edge, keeping consecutive runs gap-free.
  assign in_ready   = !run || (out_ready && rem_zero);
  assign out_valid  = run;
  assign busy       = run;
  assign out_data   = data_q;
  assign out_last   = run && rem_zero;
  assign pairs_done = pairs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      pairs_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            rem_q  <= in_count;
            state  <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (!rem_zero) begin
              rem_q <= rem_q - CNT_W'(1);
            end else begin
              pairs_q <= pairs_q + PAIR_W'(1);
              if (in_valid) begin
                data_q <= in_data;
                rem_q  <= in_count;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: directed scenarios plus random traffic,
// checked against a queue of expected output words.
module tb_rle_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] pairs_done;

  rle_decoder #(.DATA_W(32), .CNT_W(8), .PAIR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_count   (in_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .pairs_done (pairs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } word_t;

  // Reference: every word still owed to the consumer, in order.
  word_t       exp_q[$];
  logic [15:0] exp_pairs;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit coin(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // Called at posedge+1; drives inputs, checks at negedge, advances the model.
  task automatic step(input bit iv, input logic [31:0] id, input logic [7:0] ic,
                      input bit ordy, output bit acc);
    bit exp_v;
    bit exp_rdy;
    int cnt;
    in_valid  = iv;
    in_data   = id;
    in_count  = ic;
    out_ready = ordy;
    @(negedge clk);
    exp_v   = (exp_q.size() != 0);
    exp_rdy = !exp_v || (exp_q.size() == 1 && ordy);
    check("out_valid", out_valid, exp_v);
    check("busy", busy, exp_v);
    check("in_ready", in_ready, exp_rdy);
    check("pairs_done", pairs_done, exp_pairs);
    if (exp_v) begin
      check("out_data", out_data, exp_q[0].data);
      check("out_last", out_last, exp_q[0].last);
    end
    if (exp_v && ordy) begin
      if (exp_q[0].last) exp_pairs++;
      void'(exp_q.pop_front());
    end
    acc = iv && exp_rdy;
    if (acc) begin
      cnt = ic;
      for (int k = 0; k <= cnt; k++) exp_q.push_back('{id, k == cnt});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] c, input int pct);
    bit acc = 0;
    for (int i = 0; i < 2000 && !acc; i++) step(1'b1, d, c, coin(pct), acc);
    if (!acc) check("send_accept", 32'(acc), 1);
  endtask

  task automatic drain(input int pct);
    bit acc;
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step(1'b0, '0, '0, coin(pct), acc);
    check("drain_idle", out_valid, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = '0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_pairs = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pairs", pairs_done, 0);
    check("rst_in_ready", in_ready, 1);

    // Single 4-word run.
    send(32'hDEADBEEF, 8'd3, 100);
    drain(100);
    check("pairs_after_run4", pairs_done, 1);

    // Back-to-back pairs with in_valid held high.
    send(32'h1111_1111, 8'd0, 100);
    send(32'h0000_0000, 8'd1, 100);
    drain(100);
    check("pairs_after_b2b", pairs_done, 3);

    // Maximum run length.
    send(32'h5555_5555, 8'd255, 100);
    drain(100);
    check("pairs_after_max", pairs_done, 4);

    // Back-pressure pattern.
    send(32'hA5A5_A5A5, 8'd2, 100);
    foreach (pat[i]) step(1'b0, '0, '0, pat[i], acc);
    check("pairs_after_bp", pairs_done, 5);

    // Reset mid-run: two of five words emitted, then asynchronous abort.
    send(32'h1234_5678, 8'd4, 100);
    step(1'b0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_pairs", pairs_done, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    exp_pairs = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0000_0009, 8'd0, 100);
    drain(100);
    check("pairs_after_abort", pairs_done, 1);

    // Random traffic with back-pressure and input gaps.
    for (int p = 0; p < 300; p++) begin
      logic [7:0] c;
      if ($urandom_range(0, 3) == 0) step(1'b0, '0, '0, coin(70), acc);
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      send($urandom, c, 70);
    end
    drain(70);

    // Counter wrap: 65536 single-word pairs from a clean reset.
    do_reset();
    for (int p = 0; p < 65536; p++) send($urandom, 8'd0, 100);
    drain(100);
    check("pairs_wrap", pairs_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
